// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve queue.
package bp_pkg;

    localparam int unsigned PC_W_DEFAULT  = 32;
    localparam int unsigned IDX_W_DEFAULT = 10;
    localparam int unsigned PC_INC        = 4;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]  pc;
        logic                     pred_taken;
        logic [PC_W_DEFAULT-1:0]  pred_target;
        logic [IDX_W_DEFAULT-1:0] gpt_idx;
    } bp_entry_t;

endpackage

// File: rtl/bp_fifo.sv
// Synchronous FIFO with a clear that outranks push/pop; head is read combinationally.
module bp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    always_comb begin
        o_full    = (r_count == CW'(DEPTH));
        o_empty   = (r_count == '0);
        w_push_ok = i_push && !o_full;
        w_pop_ok  = i_pop && !o_empty;
        o_head    = r_mem[r_rd_ptr];
        o_count   = r_count;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue: compares the oldest prediction with the resolved
// outcome and emits registered predictor-update / redirect / error pulses.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = bp_pkg::IDX_W_DEFAULT,
    parameter int unsigned PC_W  = bp_pkg::PC_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    input  logic [PC_W-1:0]        push_pc,
    input  logic                   push_pred_taken,
    input  logic [PC_W-1:0]        push_pred_target,
    input  logic [IDX_W-1:0]       push_gpt_idx,
    output logic                   push_ready,
    input  logic                   res_valid,
    input  logic [PC_W-1:0]        res_pc,
    input  logic                   res_taken,
    input  logic [PC_W-1:0]        res_target,
    input  logic                   ext_flush,
    output logic                   upd_valid,
    output logic                   upd_taken,
    output logic [PC_W-1:0]        upd_pc,
    output logic [IDX_W-1:0]       upd_gpt_idx,
    output logic                   mispredict,
    output logic [PC_W-1:0]        redirect_pc,
    output logic                   err_unmatched,
    output logic [$clog2(DEPTH):0] occupancy
);

    import bp_pkg::*;

    // Same layout as bp_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             pred_taken;
        logic [PC_W-1:0]  pred_target;
        logic [IDX_W-1:0] gpt_idx;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    entry_t                 w_push_entry;
    entry_t                 w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_match;
    logic                   w_mismatch;
    logic                   w_pred_wrong;
    logic                   w_redirect_en;
    logic                   w_clear;
    logic                   w_err;
    logic [PC_W-1:0]        w_redirect;
    logic [$clog2(DEPTH):0] w_count;

    logic                   r_upd_valid;
    logic                   r_upd_taken;
    logic [PC_W-1:0]        r_upd_pc;
    logic [IDX_W-1:0]       r_upd_gpt_idx;
    logic                   r_mispredict;
    logic [PC_W-1:0]        r_redirect_pc;
    logic                   r_err_unmatched;

    always_comb begin
        w_push_entry.pc          = push_pc;
        w_push_entry.pred_taken  = push_pred_taken;
        w_push_entry.pred_target = push_pred_target;
        w_push_entry.gpt_idx     = push_gpt_idx;

        w_match      = res_valid && !w_empty && (w_head.pc == res_pc);
        w_mismatch   = res_valid && !w_empty && (w_head.pc != res_pc);
        w_pred_wrong = (w_head.pred_taken != res_taken) ||
                       (w_head.pred_taken && res_taken && (w_head.pred_target != res_target));
        w_redirect_en = w_mismatch || (w_match && w_pred_wrong);
        w_err        = (res_valid && w_empty) || w_mismatch;
        w_clear      = ext_flush || w_redirect_en;
        w_redirect   = res_taken ? res_target : (res_pc + PC_W'(PC_INC));
    end

    bp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (push_valid),
        .i_data  (w_push_entry),
        .i_pop   (w_match),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Payload registers hold their last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_valid     <= 1'b0;
            r_upd_taken     <= 1'b0;
            r_upd_pc        <= '0;
            r_upd_gpt_idx   <= '0;
            r_mispredict    <= 1'b0;
            r_redirect_pc   <= '0;
            r_err_unmatched <= 1'b0;
        end else begin
            r_upd_valid     <= w_match;
            r_mispredict    <= w_redirect_en;
            r_err_unmatched <= w_err;
            if (w_match) begin
                r_upd_taken   <= res_taken;
                r_upd_pc      <= res_pc;
                r_upd_gpt_idx <= w_head.gpt_idx;
            end
            if (w_redirect_en)
                r_redirect_pc <= w_redirect;
        end
    end

    assign push_ready    = !w_full;
    assign occupancy     = w_count;
    assign upd_valid     = r_upd_valid;
    assign upd_taken     = r_upd_taken;
    assign upd_pc        = r_upd_pc;
    assign upd_gpt_idx   = r_upd_gpt_idx;
    assign mispredict    = r_mispredict;
    assign redirect_pc   = r_redirect_pc;
    assign err_unmatched = r_err_unmatched;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a reference queue and output scoreboard.
module tb_branch_resolve_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic [PC_W-1:0]  push_pc;
    logic             push_pred_taken;
    logic [PC_W-1:0]  push_pred_target;
    logic [IDX_W-1:0] push_gpt_idx;
    logic             push_ready;
    logic             res_valid;
    logic [PC_W-1:0]  res_pc;
    logic             res_taken;
    logic [PC_W-1:0]  res_target;
    logic             ext_flush;
    logic             upd_valid;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_pc;
    logic [IDX_W-1:0] upd_gpt_idx;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             err_unmatched;
    logic [2:0]       occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             pt;
        logic [PC_W-1:0]  tgt;
        logic [IDX_W-1:0] idx;
    } ent_t;

    typedef struct packed {
        logic             upd_valid;
        logic             upd_taken;
        logic [PC_W-1:0]  upd_pc;
        logic [IDX_W-1:0] upd_idx;
        logic             mispredict;
        logic [PC_W-1:0]  redirect;
        logic             err;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    exp_t prev = '0;

    always #5 clk = ~clk;

    branch_resolve_queue #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .PC_W  (PC_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_gpt_idx     (push_gpt_idx),
        .push_ready       (push_ready),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .ext_flush        (ext_flush),
        .upd_valid        (upd_valid),
        .upd_taken        (upd_taken),
        .upd_pc           (upd_pc),
        .upd_gpt_idx      (upd_gpt_idx),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .err_unmatched    (err_unmatched),
        .occupancy        (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0;
        push_pred_target = '0; push_gpt_idx = '0; res_valid = 1'b0; res_pc = '0;
        res_taken = 1'b0; res_target = '0; ext_flush = 1'b0;
    endtask

    // Predict outputs from the reference queue, advance one edge, then compare.
    task automatic step();
        exp_t e;
        bit hv, match, mm, mis, full;
        ent_t ne;
        e = prev;
        e.upd_valid = 1'b0; e.mispredict = 1'b0; e.err = 1'b0;
        hv    = (mq.size() != 0);
        match = res_valid && hv && (mq[0].pc == res_pc);
        mm    = res_valid && hv && !match;
        mis   = mm || (match && ((mq[0].pt != res_taken) ||
                                 (mq[0].pt && res_taken && (mq[0].tgt != res_target))));
        if (match) begin
            e.upd_valid = 1'b1; e.upd_taken = res_taken; e.upd_pc = res_pc; e.upd_idx = mq[0].idx;
        end
        if (mis) begin
            e.mispredict = 1'b1;
            e.redirect   = res_taken ? res_target : res_pc + 32'd4;
        end
        e.err = (res_valid && !hv) || mm;
        full  = (mq.size() == DEPTH);
        if (rst) begin
            e = '0;
            mq.delete();
        end else if (ext_flush || mis) begin
            mq.delete();
        end else begin
            if (match) void'(mq.pop_front());
            if (push_valid && !full) begin
                ne.pc = push_pc; ne.pt = push_pred_taken; ne.tgt = push_pred_target; ne.idx = push_gpt_idx;
                mq.push_back(ne);
            end
        end
        sb.push_back(e);
        prev = e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("upd_valid",     64'(upd_valid),     64'(e.upd_valid));
        chk("upd_taken",     64'(upd_taken),     64'(e.upd_taken));
        chk("upd_pc",        64'(upd_pc),        64'(e.upd_pc));
        chk("upd_gpt_idx",   64'(upd_gpt_idx),   64'(e.upd_idx));
        chk("mispredict",    64'(mispredict),    64'(e.mispredict));
        chk("redirect_pc",   64'(redirect_pc),   64'(e.redirect));
        chk("err_unmatched", 64'(err_unmatched), 64'(e.err));
        chk("occupancy",     64'(occupancy),     64'(mq.size()));
        chk("push_ready",    64'(push_ready),    64'(mq.size() < DEPTH));
        idle();
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                            input logic [9:0] idx);
        push_valid = 1'b1; push_pc = pc; push_pred_taken = pt; push_pred_target = tgt; push_gpt_idx = idx;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1'b1; step();
        rst = 1'b1; step();
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_ready", 64'(push_ready), 64'd1);

        // Correct not-taken prediction
        set_push(32'h100, 1'b0, 32'h0, 10'h05); step();
        chk("t1_occ1", 64'(occupancy), 64'd1);
        set_res(32'h100, 1'b0, 32'h0); step();
        chk("t1_upd", 64'(upd_valid), 64'd1);
        chk("t1_idx", 64'(upd_gpt_idx), 64'h05);
        chk("t1_mis", 64'(mispredict), 64'd0);
        chk("t1_occ0", 64'(occupancy), 64'd0);

        // Predicted taken, actually not taken
        set_push(32'h200, 1'b1, 32'h240, 10'h07); step();
        set_res(32'h200, 1'b0, 32'h0); step();
        chk("t2_mis", 64'(mispredict), 64'd1);
        chk("t2_redir", 64'(redirect_pc), 64'h204);
        chk("t2_taken", 64'(upd_taken), 64'd0);

        // Wrong target flushes younger entries
        set_push(32'h300, 1'b1, 32'h380, 10'h10); step();
        set_push(32'h304, 1'b0, 32'h0, 10'h11); step();
        set_push(32'h308, 1'b0, 32'h0, 10'h12); step();
        set_res(32'h300, 1'b1, 32'h390); step();
        chk("t3_mis", 64'(mispredict), 64'd1);
        chk("t3_redir", 64'(redirect_pc), 64'h390);
        chk("t3_occ", 64'(occupancy), 64'd0);

        // Fill, overflow, then push+pop at full and below full
        set_push(32'h400, 1'b0, 32'h0, 10'h20); step();
        set_push(32'h404, 1'b1, 32'h480, 10'h21); step();
        set_push(32'h408, 1'b0, 32'h0, 10'h22); step();
        set_push(32'h40C, 1'b0, 32'h0, 10'h23); step();
        chk("t4_full", 64'(push_ready), 64'd0);
        set_push(32'h410, 1'b0, 32'h0, 10'h24); step();
        chk("t4_occ4", 64'(occupancy), 64'd4);
        set_push(32'h414, 1'b0, 32'h0, 10'h25); set_res(32'h400, 1'b0, 32'h0); step();
        chk("t4_nobypass", 64'(occupancy), 64'd3);
        set_push(32'h418, 1'b0, 32'h0, 10'h26); set_res(32'h404, 1'b1, 32'h480); step();
        chk("t4_pp_occ", 64'(occupancy), 64'd3);
        chk("t4_pp_mis", 64'(mispredict), 64'd0);
        set_res(32'h408, 1'b0, 32'h0); step();
        set_res(32'h40C, 1'b0, 32'h0); step();
        set_res(32'h418, 1'b0, 32'h0); step();
        chk("t4_order_idx", 64'(upd_gpt_idx), 64'h26);
        chk("t4_empty", 64'(occupancy), 64'd0);

        // Unmatched resolves
        set_res(32'h600, 1'b0, 32'h0); step();
        chk("t5_err_empty", 64'(err_unmatched), 64'd1);
        chk("t5_mis_empty", 64'(mispredict), 64'd0);
        set_push(32'h504, 1'b0, 32'h0, 10'h30); step();
        set_res(32'h500, 1'b1, 32'h5A0); step();
        chk("t5_err_pc", 64'(err_unmatched), 64'd1);
        chk("t5_mis_pc", 64'(mispredict), 64'd1);
        chk("t5_upd_pc", 64'(upd_valid), 64'd0);
        chk("t5_redir", 64'(redirect_pc), 64'h5A0);

        // External flush, with concurrent push and with concurrent resolve
        set_push(32'h700, 1'b0, 32'h0, 10'h40); step();
        set_push(32'h704, 1'b0, 32'h0, 10'h41); step();
        set_push(32'h708, 1'b0, 32'h0, 10'h42); ext_flush = 1'b1; step();
        chk("t6_flush_occ", 64'(occupancy), 64'd0);
        set_push(32'h800, 1'b0, 32'h0, 10'h50); step();
        set_push(32'h804, 1'b0, 32'h0, 10'h51); step();
        set_res(32'h800, 1'b0, 32'h0); ext_flush = 1'b1; step();
        chk("t6_flush_upd", 64'(upd_valid), 64'd1);
        chk("t6_flush_occ2", 64'(occupancy), 64'd0);

        // Reset with entries in flight
        set_push(32'h900, 1'b1, 32'h990, 10'h60); step();
        set_push(32'h904, 1'b0, 32'h0, 10'h61); step();
        set_push(32'h908, 1'b0, 32'h0, 10'h62); step();
        set_res(32'h900, 1'b0, 32'h0); rst = 1'b1; step();
        chk("t7_rst_occ", 64'(occupancy), 64'd0);
        chk("t7_rst_ready", 64'(push_ready), 64'd1);
        chk("t7_rst_pc", 64'(upd_pc), 64'd0);
        step();
        chk("t7_post_upd", 64'(upd_valid), 64'd0);
        chk("t7_post_mis", 64'(mispredict), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
